// File: rtl/drsstc_led_pkg.sv
// Shared constants for the LED activity indicator: mode codes, LED drive
// levels, the per-channel FSM encoding and a counter-width helper.
package drsstc_led_pkg;

  localparam logic [1:0] MODE_ACT   = 2'b00;
  localparam logic [1:0] MODE_OFF   = 2'b01;
  localparam logic [1:0] MODE_ON    = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  // LEDs are driven active-low
  localparam logic LED_LIT  = 1'b0;
  localparam logic LED_DARK = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } act_state_e;

  // Width for a down-counter loaded with at most max(a,b)-1; never below 1 bit
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_act_stretch.sv
// One LED channel: async input synchroniser, rising-edge detect, and the
// IDLE/ON/GAP stretch FSM. Events arriving during ON/GAP collapse into a
// single pending flash that starts right after the gap.
module led_act_stretch
  import drsstc_led_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYC = 2000000,
  parameter int GAP_CYC     = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic evt_in,
  output logic on,
  output logic busy
);

  localparam int CW = cnt_width(STRETCH_CYC, GAP_CYC);
  localparam logic [CW-1:0] STRETCH_LD = CW'(STRETCH_CYC - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   evt;
  act_state_e             state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   pend, pend_n;

  // Synchroniser chain plus the delayed copy used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], evt_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign evt = sync[SYNC_STAGES-1] & ~prev;

  // FSM state, stretch/gap counter and pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
    end
  end

  // Next-state: ON lasts STRETCH_CYC cycles, GAP lasts GAP_CYC cycles
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    case (state)
      IDLE: begin
        if (evt) begin
          state_n = ON;
          cnt_n   = STRETCH_LD;
          pend_n  = 1'b0;
        end
      end
      ON: begin
        pend_n = pend | evt;
        if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = GAP_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          pend_n = 1'b0;
          if (pend | evt) begin
            state_n = ON;
            cnt_n   = STRETCH_LD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          pend_n = pend | evt;
          cnt_n  = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

  assign on   = (state == ON);
  assign busy = (state != IDLE);

endmodule

// File: rtl/led_activity_indicator.sv
// Multi-channel active-low LED driver: per-channel activity stretchers, a
// shared blink generator, per-channel mode mux, DIP test override and
// registered outputs. Optional dimming PWM is enabled by LED_DIM_PWM_EN,
// which adds the DIM input.
module led_activity_indicator
  import drsstc_led_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYC    = 2000000,
  parameter int GAP_CYC        = 2000000,
  parameter int BLINK_HALF_CYC = 10000000
) (
  input  logic                  CLK_40M,
  input  logic                  RST,
  input  logic [NUM_CH-1:0]     EVT_IN,
  input  logic [2*NUM_CH-1:0]   MODE,
  input  logic                  TEST_EN,
  input  logic [NUM_CH-1:0]     TEST_PAT,
`ifdef LED_DIM_PWM_EN
  input  logic [2:0]            DIM,
`endif
  output logic [NUM_CH-1:0]     LED_N,
  output logic [NUM_CH-1:0]     ACT_BUSY
);

  localparam int BW = (BLINK_HALF_CYC < 2) ? 1 : $clog2(BLINK_HALF_CYC);

  logic [NUM_CH-1:0] ch_on, ch_busy, lit, led_n_next;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;
  logic              pwm_ok;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    led_act_stretch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STRETCH_CYC (STRETCH_CYC),
      .GAP_CYC     (GAP_CYC)
    ) u_ch (
      .clk    (CLK_40M),
      .rst    (RST),
      .evt_in (EVT_IN[k]),
      .on     (ch_on[k]),
      .busy   (ch_busy[k])
    );
  end

  // Free-running blink generator shared by all channels
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF_CYC - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

`ifdef LED_DIM_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running dimming PWM; top three bits compared against DIM
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_ok = (pwm_cnt[7:5] <= DIM);
`else
  assign pwm_ok = 1'b1;
`endif

  // Mode mux, dimming gate and test override (test bypasses dimming)
  always_comb begin
    lit        = '0;
    led_n_next = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      case (MODE[2*k +: 2])
        MODE_ACT: lit[k] = ch_on[k];
        MODE_OFF: lit[k] = 1'b0;
        MODE_ON:  lit[k] = 1'b1;
        default:  lit[k] = blink_phase;
      endcase
      if (TEST_EN) led_n_next[k] = ~TEST_PAT[k];
      else         led_n_next[k] = (lit[k] & pwm_ok) ? LED_LIT : LED_DARK;
    end
  end

  // Registered LED drives and busy flags
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      LED_N    <= '1;
      ACT_BUSY <= '0;
    end else begin
      LED_N    <= led_n_next;
      ACT_BUSY <= ch_busy;
    end
  end

endmodule

// File: doc/led_activity_indicator.md
Name: led_activity_indicator

Overview:
- Parametrised multi-channel LED driver for the SFP transceiver board; replaces direct DIP-to-LED wiring on the TX/RX indicators.
- Per channel: asynchronous activity input synchronised, edge-detected, stretched to a visible ON pulse, then held OFF for a minimum gap so sustained traffic blinks.
- Per-channel mode select (activity / off / on / blink) plus a global DIP test override.
- Outputs active-low LED drives.

Parameters:
- NUM_CH, 4, number of LED channels (1..16).
- SYNC_STAGES, 2, synchroniser depth on EVT_IN (>=2).
- STRETCH_CYC, 2000000, ON duration in CLK_40M cycles (50 ms at 40 MHz), >=1.
- GAP_CYC, 2000000, minimum OFF gap after a stretch, >=1.
- BLINK_HALF_CYC, 10000000, blink half-period (2 Hz at 40 MHz), >=1.

Ports:
- CLK_40M  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- EVT_IN  in  NUM_CH  asynchronous activity inputs; rising edge = event.
- MODE  in  2*NUM_CH  per-channel mode, channel k = MODE[2k+1:2k]; quasi-static.
- TEST_EN  in  1  test override enable (DIP).
- TEST_PAT  in  NUM_CH  test pattern; 1 = LED lit.
- LED_N  out  NUM_CH  LED drive, active-low, registered.
- ACT_BUSY  out  NUM_CH  channel FSM not in IDLE, registered.

Behaviour:
- Reset (async): sync chains, edge registers, pending flags, counters and blink counter cleared; FSMs to IDLE; blink phase off; LED_N = all 1; ACT_BUSY = all 0.
- Edge detect: evt = sync_last & ~prev; prev updates every cycle.
- Per-channel FSM, counter width $clog2(max(STRETCH_CYC, GAP_CYC)):
  - IDLE: evt -> ON, cnt = STRETCH_CYC-1.
  - ON: cnt decrements; evt sets pending; cnt==0 -> GAP, cnt = GAP_CYC-1.
  - GAP: cnt decrements; evt sets pending; cnt==0 -> ON if pending (or evt this cycle), else IDLE.
  - Entering ON clears pending.
  - Multiple events during ON/GAP collapse into one pending flash.
- Timing: lit for exactly STRETCH_CYC cycles and dark for at least GAP_CYC cycles.
- Latency: LED_N falls at the (SYNC_STAGES+2)th rising edge after the edge that first samples EVT_IN high.
- FSMs run in every mode; the mode only selects the output.
- Mode: 00 ACT (lit while FSM in ON), 01 OFF, 10 ON, 11 BLINK.
- Blink generator: shared free-running counter; phase toggles every BLINK_HALF_CYC cycles; first toggle BLINK_HALF_CYC cycles after reset release.
- TEST_EN=1: LED_N = ~TEST_PAT on the next edge, overriding the mode.
- ACT_BUSY = (state != IDLE), registered alongside LED_N.
- EVT_IN held high through reset release: the chain starts at 0, giving one rising edge and exactly one flash.
- Reset mid-ON/GAP: LED_N returns to 1 immediately; no pending carry-over.

Optional Feature:
- LED_DIM_PWM_EN defined:
  - Adds input DIM (3 bits) and a free-running 8-bit pwm_cnt.
  - A lit LED (any source except TEST_EN) is driven low only while pwm_cnt[7:5] <= DIM; DIM=7 gives full on, DIM=0 gives 32/256.
  - pwm_cnt resets to 0.
- Undefined: no DIM port, no pwm_cnt; lit LEDs are continuously low.

Decomposition:
- Package drsstc_led_pkg holds:
  - mode localparams MODE_ACT=2'b00, MODE_OFF=2'b01, MODE_ON=2'b10, MODE_BLINK=2'b11;
  - LED_LIT=1'b0 and LED_DARK=1'b1;
  - FSM state encoding IDLE/ON/GAP.
- Sub-module led_act_stretch: one channel's synchroniser, edge detect, FSM and counter; instantiated NUM_CH times by generate.
- The top level holds the blink generator, optional PWM, mode mux and output registers.

Test Plan (NUM_CH=4, SYNC_STAGES=2, STRETCH_CYC=8, GAP_CYC=4, BLINK_HALF_CYC=16, MODE all 00):
- Single-cycle EVT_IN[0] pulse -> LED_N[0] low from the 4th edge after sampling, for exactly 8 cycles, then 1; ACT_BUSY[0] high for 12 cycles; other channels stay 1.
- EVT_IN[1] toggling every 2 cycles for 40 cycles -> LED_N[1] repeats 8 low / 4 high; one extra flash after input stops (pending); never two flashes without a 4-cycle gap.
- MODE ch0=10, ch1=01, ch2=11 with EVT_IN activity on all -> LED_N[0] constant 0, LED_N[1] constant 1, LED_N[2] toggles every 16 cycles; ACT_BUSY still follows activity.
- TEST_EN=1, TEST_PAT=4'b0101 -> LED_N=4'b1010 one edge later regardless of MODE/EVT_IN; TEST_EN=0 restores normal outputs next edge.
- Assert RST mid-ON -> LED_N=4'hF and ACT_BUSY=0 without a clock edge; release with EVT_IN[0] held high -> exactly one 8-cycle flash.
- With LED_DIM_PWM_EN, MODE=10, DIM=0 -> LED_N low 32 of every 256 cycles; DIM=7 -> always low.
